apb_spi_slave: RTL and testbench

//  APB-attached SPI slave (target): the far end of the team's APB SPI master. An external master drives

---
 rtl/apb_spi_slave.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_apb_spi_slave.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_spi_slave.sv
// apb_spi_slave: APB-programmed SPI target. SCLK/SSn/MOSI are oversampled in the PCLK domain.
// Build option SPI_SLV_RXFIFO_EN swaps the single RX byte register for an RXF_DEPTH-entry FIFO.
`timescale 1ns/1ps
module apb_spi_slave #(
  parameter int SYNC_STAGES = 2,
  parameter int RXF_DEPTH   = 4
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic        SCLK,
  input  logic        SSn,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_OE,
  output logic        IRQ
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] ssn_sync_q, ssn_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   ssn_prev_q, ssn_prev_d;

  logic       en_q, en_d;
  logic       cpol_q, cpol_d;
  logic       cpha_q, cpha_d;
  logic [2:0] im_q, im_d;
  logic [7:0] tx_q, tx_d;
  logic       txe_q, txe_d;
  logic       ovr_q, ovr_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rxsh_q, rxsh_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       miso_q, miso_d;
  logic       miso_oe_q, miso_oe_d;

  logic       sclk_s, ssn_s, mosi_s;
  logic       sclk_rise, sclk_fall, ssn_fall;
  logic       lead_edge, trail_edge, sample_edge, shift_edge;
  logic       apb_wr, apb_rd, pop;
  logic       push;
  logic [7:0] push_data;
  logic [7:0] load_val;
  logic       busy;

  logic       rx_empty, rx_full;
  logic [7:0] rx_head;
  logic [2:0] rx_level;

  logic       unused_bits;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign ssn_s  = ssn_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ssn_fall  = ~ssn_s & ssn_prev_q;

  // Leading edge is SCLK leaving its idle (CPOL) level; CPHA picks which edge samples.
  assign lead_edge   = cpol_q ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trail_edge : lead_edge;
  assign shift_edge  = cpha_q ? lead_edge : trail_edge;

  assign apb_wr   = PSEL & PENABLE & PWRITE;
  assign apb_rd   = PSEL & PENABLE & ~PWRITE;
  assign pop      = apb_rd & (PADDR[4:2] == 3'd0) & ~rx_empty;
  assign load_val = txe_q ? 8'h00 : tx_q;
  assign busy     = (state_q == ACTIVE);

  assign PREADY  = 1'b1;
  assign MISO    = miso_q;
  assign MISO_OE = miso_oe_q;
  assign IRQ     = |(im_q & {ovr_q, txe_q, ~rx_empty});

  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:8]};

`ifdef SPI_SLV_RXFIFO_EN
  localparam int PW = (RXF_DEPTH > 1) ? $clog2(RXF_DEPTH) : 1;

  logic [7:0]  rx_mem_q [RXF_DEPTH];
  logic [7:0]  rx_mem_d [RXF_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   rx_cnt_q, rx_cnt_d;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (32'(rx_cnt_q) == RXF_DEPTH);
  assign rx_head  = rx_mem_q[rd_ptr_q];
  assign rx_level = (32'(rx_cnt_q) > 32'd7) ? 3'd7 : 3'(rx_cnt_q);

  always_comb begin
    rx_mem_d = rx_mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rx_cnt_d = rx_cnt_q;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && (!rx_full || pop)) begin
      rx_mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    case ({push && (!rx_full || pop), pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < RXF_DEPTH; i++) begin
        rx_mem_q[i] <= 8'h00;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      rx_cnt_q <= '0;
    end else begin
      rx_mem_q <= rx_mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rx_cnt_q <= rx_cnt_d;
    end
  end
`else
  logic [7:0] rx_data_q, rx_data_d;
  logic       rxne_q, rxne_d;
  logic       unused_depth;

  assign rx_empty     = ~rxne_q;
  assign rx_full      = rxne_q;
  assign rx_head      = rx_data_q;
  assign rx_level     = 3'd0;
  assign unused_depth = ^RXF_DEPTH;

  // A pop and a push landing together both take effect, so the register stays full.
  always_comb begin
    rx_data_d = rx_data_q;
    rxne_d    = rxne_q;
    if (pop) begin
      rxne_d = 1'b0;
    end
    if (push && (!rx_full || pop)) begin
      rx_data_d = push_data;
      rxne_d    = 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_data_q <= 8'h00;
      rxne_q    <= 1'b0;
    end else begin
      rx_data_q <= rx_data_d;
      rxne_q    <= rxne_d;
    end
  end
`endif

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    ssn_sync_d  = {ssn_sync_q[SYNC_STAGES-2:0], SSn};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    sclk_prev_d = sclk_s;
    ssn_prev_d  = ssn_s;

    state_d   = state_q;
    en_d      = en_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    im_d      = im_q;
    tx_d      = tx_q;
    txe_d     = txe_q;
    ovr_d     = ovr_q;
    shift_d   = shift_q;
    rxsh_d    = rxsh_q;
    bitcnt_d  = bitcnt_q;
    miso_d    = miso_q;
    miso_oe_d = en_q & ~ssn_s;
    push      = 1'b0;
    push_data = 8'h00;

    case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (en_q && ssn_fall) begin
          state_d  = ACTIVE;
          txe_d    = 1'b1;
          bitcnt_d = 3'd0;
          // CPHA=0 masters sample on the very first edge, so the MSB must already be on the pin.
          if (!cpha_q) begin
            miso_d  = load_val[7];
            shift_d = {load_val[6:0], 1'b0};
          end else begin
            shift_d = load_val;
          end
        end
      end
      ACTIVE: begin
        if (!en_q || ssn_s) begin
          state_d  = IDLE;
          bitcnt_d = 3'd0;
          miso_d   = 1'b0;
        end else if (sample_edge) begin
          rxsh_d = {rxsh_q[6:0], mosi_s};
          if (bitcnt_q == 3'd7) begin
            push      = 1'b1;
            push_data = {rxsh_q[6:0], mosi_s};
            bitcnt_d  = 3'd0;
            shift_d   = load_val;
            txe_d     = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else if (shift_edge) begin
          miso_d  = shift_q[7];
          shift_d = {shift_q[6:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    // Register writes come after the FSM so a DATA write wins TXE over a same-cycle load.
    if (apb_wr) begin
      case (PADDR[4:2])
        3'd0: begin
          tx_d  = PWDATA[7:0];
          txe_d = 1'b0;
        end
        3'd1: en_d = PWDATA[0];
        3'd2: begin
          cpol_d = PWDATA[0];
          cpha_d = PWDATA[1];
        end
        3'd4: if (PWDATA[2]) ovr_d = 1'b0;
        3'd5: im_d = PWDATA[2:0];
        default: ;
      endcase
    end

    if (push && rx_full && !pop) begin
      ovr_d = 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      sclk_sync_q <= '0;
      ssn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ssn_prev_q  <= 1'b1;
      state_q     <= IDLE;
      en_q        <= 1'b0;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      im_q        <= 3'd0;
      tx_q        <= 8'h00;
      txe_q       <= 1'b1;
      ovr_q       <= 1'b0;
      shift_q     <= 8'h00;
      rxsh_q      <= 8'h00;
      bitcnt_q    <= 3'd0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      ssn_sync_q  <= ssn_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      ssn_prev_q  <= ssn_prev_d;
      state_q     <= state_d;
      en_q        <= en_d;
      cpol_q      <= cpol_d;
      cpha_q      <= cpha_d;
      im_q        <= im_d;
      tx_q        <= tx_d;
      txe_q       <= txe_d;
      ovr_q       <= ovr_d;
      shift_q     <= shift_d;
      rxsh_q      <= rxsh_d;
      bitcnt_q    <= bitcnt_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

  always_comb begin
    PRDATA = 32'h0;
    case (PADDR[4:2])
      3'd0: PRDATA[7:0] = rx_empty ? 8'h00 : rx_head;
      3'd1: PRDATA[0]   = en_q;
      3'd2: PRDATA[1:0] = {cpha_q, cpol_q};
      3'd4: PRDATA[6:0] = {rx_level, busy, ovr_q, txe_q, ~rx_empty};
      3'd5: PRDATA[2:0] = im_q;
      default: PRDATA = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_apb_spi_slave.sv
// tb_apb_spi_slave: drives apb_spi_slave as an SPI master plus APB host (default single-register RX build).
// Expected MISO bytes and RX bytes are queued when stimulus is issued and checked when they come back.
`timescale 1ns/1ps
module tb_apb_spi_slave;

  localparam int HALF = 80;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        SCLK, SSn, MOSI;
  logic        MISO, MISO_OE, IRQ;

  logic        cpol_m, cpha_m;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  miso_exp_q[$];
  logic [7:0]  rx_exp_q[$];

  apb_spi_slave dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .SCLK(SCLK), .SSn(SSn), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 data = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    logic [31:0] v;
    apb_read(addr, v);
    checkOutput(tag, v, expected);
  endtask

  task automatic spi_select();
    SSn = 1'b0;
    #(HALF + 40);
  endtask

  task automatic spi_release();
    #(HALF);
    SSn = 1'b1;
    #(2 * HALF);
  endtask

  // Master side of one (possibly truncated) byte, MSB first, in the mode held in cpol_m/cpha_m.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha_m) begin
        MOSI = tx[i];
        #(HALF);
        SCLK = ~cpol_m;
        rx[i] = MISO;
        #(HALF);
        SCLK = cpol_m;
      end else begin
        SCLK = ~cpol_m;
        MOSI = tx[i];
        #(HALF);
        SCLK = cpol_m;
        rx[i] = MISO;
        #(HALF);
      end
    end
  endtask

  task automatic xfer_and_score(input string tag, input logic [7:0] mosi_byte);
    logic [7:0] got;
    logic [7:0] exp;
    spi_byte(mosi_byte, 8, got);
    exp = (miso_exp_q.size() > 0) ? miso_exp_q.pop_front() : 8'hxx;
    checkOutput(tag, {24'h0, got}, {24'h0, exp});
  endtask

  task automatic read_rx_and_score(input string tag);
    logic [31:0] v;
    logic [7:0]  exp;
    apb_read(32'h00, v);
    exp = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 8'hxx;
    checkOutput(tag, v, {24'h0, exp});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] dummy;
    logic [1:0] cfg;

    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'h10; PWDATA = 32'h0;
    SCLK = 1'b0; SSn = 1'b1; MOSI = 1'b0; cpol_m = 1'b0; cpha_m = 1'b0;
    repeat (3) @(negedge PCLK);
    checkOutput("rst_status", PRDATA, 32'h2);
    checkOutput("rst_miso", {31'h0, MISO}, 32'h0);
    checkOutput("rst_miso_oe", {31'h0, MISO_OE}, 32'h0);
    checkOutput("rst_irq", {31'h0, IRQ}, 32'h0);
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);

    check_reg("rst_ctrl", 32'h04, 32'h0);
    check_reg("unmapped", 32'h0C, 32'h0);
    check_reg("empty_data", 32'h00, 32'h0);

    // Mode 0 basic transfer
    apb_write(32'h04, 32'h1);
    apb_write(32'h08, 32'h0);
    apb_write(32'h00, 32'hA5);
    check_reg("txe_cleared", 32'h10, 32'h0);
    miso_exp_q.push_back(8'hA5);
    rx_exp_q.push_back(8'h3C);
    spi_select();
    checkOutput("m0_oe", {31'h0, MISO_OE}, 32'h1);
    checkOutput("m0_msb_early", {31'h0, MISO}, 32'h1);
    check_reg("m0_busy", 32'h10, 32'hA);
    xfer_and_score("m0_miso", 8'h3C);
    check_reg("m0_rxne", 32'h10, 32'hB);
    spi_release();
    checkOutput("m0_oe_off", {31'h0, MISO_OE}, 32'h0);
    check_reg("m0_idle", 32'h10, 32'h3);
    read_rx_and_score("m0_rx");
    check_reg("m0_popped", 32'h10, 32'h2);

    // Modes 1, 2, 3
    for (int m = 1; m <= 3; m++) begin
      cfg = (m == 1) ? 2'b10 : ((m == 2) ? 2'b01 : 2'b11);
      apb_write(32'h08, {30'h0, cfg});
      cpol_m = cfg[0];
      cpha_m = cfg[1];
      SCLK = cpol_m;
      #(2 * HALF);
      apb_write(32'h00, 32'h81);
      miso_exp_q.push_back(8'h81);
      rx_exp_q.push_back(8'h7E);
      spi_select();
      xfer_and_score($sformatf("mode%0d_miso", m), 8'h7E);
      spi_release();
      read_rx_and_score($sformatf("mode%0d_rx", m));
    end

    // Back-to-back bytes without reading: overrun
    apb_write(32'h08, 32'h0);
    cpol_m = 1'b0; cpha_m = 1'b0; SCLK = 1'b0;
    #(2 * HALF);
    apb_write(32'h14, 32'h4);
    miso_exp_q.push_back(8'h00);
    miso_exp_q.push_back(8'h00);
    rx_exp_q.push_back(8'h11);
    spi_select();
    xfer_and_score("b2b_miso1", 8'h11);
    xfer_and_score("b2b_miso2", 8'h22);
    spi_release();
    check_reg("ovr_status", 32'h10, 32'h7);
    checkOutput("ovr_irq", {31'h0, IRQ}, 32'h1);
    apb_write(32'h10, 32'h4);
    checkOutput("ovr_irq_clr", {31'h0, IRQ}, 32'h0);
    check_reg("ovr_cleared", 32'h10, 32'h3);
    read_rx_and_score("ovr_rx_first");

    // Partial byte discarded
    apb_write(32'h14, 32'h0);
    spi_select();
    check_reg("part_busy", 32'h10, 32'hA);
    spi_byte(8'hFF, 5, dummy);
    spi_release();
    check_reg("part_idle", 32'h10, 32'h2);
    apb_write(32'h00, 32'h5A);
    miso_exp_q.push_back(8'h5A);
    rx_exp_q.push_back(8'h96);
    spi_select();
    xfer_and_score("after_part_miso", 8'h96);
    spi_release();
    read_rx_and_score("after_part_rx");

    // Empty TX sends zero; TXE interrupt until DATA write
    apb_write(32'h14, 32'h2);
    checkOutput("txe_irq", {31'h0, IRQ}, 32'h1);
    miso_exp_q.push_back(8'h00);
    rx_exp_q.push_back(8'hC3);
    spi_select();
    xfer_and_score("txe_miso_zero", 8'hC3);
    spi_release();
    read_rx_and_score("txe_rx");
    apb_write(32'h00, 32'h55);
    checkOutput("txe_irq_clr", {31'h0, IRQ}, 32'h0);
    check_reg("txe_status", 32'h10, 32'h0);

    // Asynchronous reset in the middle of a byte
    spi_select();
    spi_byte(8'hAA, 4, dummy);
    checkOutput("pre_rst_oe", {31'h0, MISO_OE}, 32'h1);
    #3 PRESET = 1'b1;
    #1;
    checkOutput("async_rst_oe", {31'h0, MISO_OE}, 32'h0);
    checkOutput("async_rst_miso", {31'h0, MISO}, 32'h0);
    checkOutput("async_rst_irq", {31'h0, IRQ}, 32'h0);
    PADDR = 32'h10;
    #1 checkOutput("async_rst_status", PRDATA, 32'h2);
    PADDR = 32'h04;
    #1 checkOutput("async_rst_ctrl", PRDATA, 32'h0);
    PADDR = 32'h08;
    #1 checkOutput("async_rst_cfg", PRDATA, 32'h0);
    PADDR = 32'h14;
    #1 checkOutput("async_rst_im", PRDATA, 32'h0);
    SSn = 1'b1; SCLK = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (2) @(negedge PCLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
